// File: rtl/axi4lite_arbiter_2to1.sv
// Two-master, one-slave AXI4-Lite arbiter with independent round-robin read and write paths.
// Optional response timeout with DECERR completion is enabled by defining AXI_ARB_TIMEOUT_EN.
module axi4lite_arbiter_2to1 #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int SWIDTH = DWIDTH / 8
`ifdef AXI_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic                  i_aClk,
    input  logic                  i_aReset,
    input  logic [1:0]            i_m_arValid,
    output logic [1:0]            o_m_arReady,
    input  logic [2*AWIDTH-1:0]   i_m_arAddr,
    input  logic [5:0]            i_m_arProt,
    output logic [1:0]            o_m_rValid,
    input  logic [1:0]            i_m_rReady,
    output logic [DWIDTH-1:0]     o_m_rData,
    output logic [1:0]            o_m_rResp,
    input  logic [1:0]            i_m_awValid,
    output logic [1:0]            o_m_awReady,
    input  logic [2*AWIDTH-1:0]   i_m_awAddr,
    input  logic [5:0]            i_m_awProt,
    input  logic [1:0]            i_m_wValid,
    output logic [1:0]            o_m_wReady,
    input  logic [2*DWIDTH-1:0]   i_m_wData,
    input  logic [2*SWIDTH-1:0]   i_m_wStrb,
    output logic [1:0]            o_m_bValid,
    input  logic [1:0]            i_m_bReady,
    output logic [1:0]            o_m_bResp,
    output logic                  o_s_arValid,
    input  logic                  i_s_arReady,
    output logic [AWIDTH-1:0]     o_s_arAddr,
    output logic [2:0]            o_s_arProt,
    input  logic                  i_s_rValid,
    output logic                  o_s_rReady,
    input  logic [DWIDTH-1:0]     i_s_rData,
    input  logic [1:0]            i_s_rResp,
    output logic                  o_s_awValid,
    input  logic                  i_s_awReady,
    output logic [AWIDTH-1:0]     o_s_awAddr,
    output logic [2:0]            o_s_awProt,
    output logic                  o_s_wValid,
    input  logic                  i_s_wReady,
    output logic [DWIDTH-1:0]     o_s_wData,
    output logic [SWIDTH-1:0]     o_s_wStrb,
    input  logic                  i_s_bValid,
    output logic                  o_s_bReady,
    input  logic [1:0]            i_s_bResp
`ifdef AXI_ARB_TIMEOUT_EN
    ,
    output logic [1:0]            o_timeout
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // lastVld distinguishes "nothing served yet" so master 0 wins the first contest.
    function automatic logic rr_pick(input logic [1:0] req, input logic last, input logic last_vld);
        logic pick;
        if (req == 2'b11) begin
            if (last_vld) begin
                pick = ~last;
            end else begin
                pick = 1'b0;
            end
        end else begin
            pick = req[1];
        end
        return pick;
    endfunction

    logic [1:0] r_rd_state, r_wr_state;
    logic       r_rd_grant, r_rd_last, r_rd_last_vld;
    logic       r_wr_grant, r_wr_last, r_wr_last_vld;
    logic       r_aw_done, r_w_done;

    logic [1:0] w_rd_oh, w_wr_oh, w_wr_req;
    logic       w_rd_pick, w_wr_pick, w_rd_arvalid, w_wr_awvalid, w_wr_wvalid;
    logic       w_ar_fire, w_r_fire, w_aw_fire, w_w_fire, w_b_fire, w_aw_now, w_w_now;
    logic       w_rd_to, w_wr_to, w_rd_drain, w_wr_drain;

    assign w_rd_oh      = r_rd_grant ? 2'b10 : 2'b01;
    assign w_wr_oh      = r_wr_grant ? 2'b10 : 2'b01;
    assign w_wr_req     = i_m_awValid | i_m_wValid;
    assign w_rd_pick    = rr_pick(i_m_arValid, r_rd_last, r_rd_last_vld);
    assign w_wr_pick    = rr_pick(w_wr_req, r_wr_last, r_wr_last_vld);
    assign w_rd_arvalid = r_rd_grant ? i_m_arValid[1] : i_m_arValid[0];
    assign w_wr_awvalid = r_wr_grant ? i_m_awValid[1] : i_m_awValid[0];
    assign w_wr_wvalid  = r_wr_grant ? i_m_wValid[1] : i_m_wValid[0];
    assign w_ar_fire    = o_s_arValid & i_s_arReady;
    assign w_r_fire     = |(o_m_rValid & i_m_rReady);
    assign w_aw_fire    = o_s_awValid & i_s_awReady;
    assign w_w_fire     = o_s_wValid & i_s_wReady;
    assign w_b_fire     = |(o_m_bValid & i_m_bReady);
    assign w_aw_now     = r_aw_done | w_aw_fire;
    assign w_w_now      = r_w_done | w_w_fire;

    // Read-path channel muxing; everything is quiet while idle or in reset.
    always_comb begin
        o_m_arReady = 2'b00;
        o_s_arValid = 1'b0;
        o_s_arAddr  = {AWIDTH{1'b0}};
        o_s_arProt  = 3'b000;
        o_m_rValid  = 2'b00;
        o_s_rReady  = 1'b0;
        o_m_rData   = {DWIDTH{1'b0}};
        o_m_rResp   = 2'b00;
        if (!i_aReset) begin
            case (r_rd_state)
                ST_ADDR: begin
                    o_s_arValid = w_rd_arvalid;
                    o_s_arAddr  = r_rd_grant ? i_m_arAddr[2*AWIDTH-1:AWIDTH] : i_m_arAddr[AWIDTH-1:0];
                    o_s_arProt  = r_rd_grant ? i_m_arProt[5:3] : i_m_arProt[2:0];
                    o_m_arReady = w_rd_oh & {2{i_s_arReady}};
                end
                ST_RESP: begin
                    if (w_rd_to) begin
                        o_m_rValid = w_rd_oh;
                        o_m_rResp  = 2'b11;
                    end else begin
                        o_m_rValid = w_rd_oh & {2{i_s_rValid}};
                        o_s_rReady = r_rd_grant ? i_m_rReady[1] : i_m_rReady[0];
                        o_m_rData  = i_s_rData;
                        o_m_rResp  = i_s_rResp;
                    end
                end
                default: o_s_rReady = w_rd_drain;
            endcase
        end else begin
            o_s_rReady = 1'b0;
        end
    end

    // Write-path channel muxing; a completed AW or W is masked until the path leaves ADDR.
    always_comb begin
        o_m_awReady = 2'b00;
        o_s_awValid = 1'b0;
        o_s_awAddr  = {AWIDTH{1'b0}};
        o_s_awProt  = 3'b000;
        o_m_wReady  = 2'b00;
        o_s_wValid  = 1'b0;
        o_s_wData   = {DWIDTH{1'b0}};
        o_s_wStrb   = {SWIDTH{1'b0}};
        o_m_bValid  = 2'b00;
        o_s_bReady  = 1'b0;
        o_m_bResp   = 2'b00;
        if (!i_aReset) begin
            case (r_wr_state)
                ST_ADDR: begin
                    o_s_awValid = w_wr_awvalid & ~r_aw_done;
                    o_s_awAddr  = r_wr_grant ? i_m_awAddr[2*AWIDTH-1:AWIDTH] : i_m_awAddr[AWIDTH-1:0];
                    o_s_awProt  = r_wr_grant ? i_m_awProt[5:3] : i_m_awProt[2:0];
                    o_m_awReady = w_wr_oh & {2{i_s_awReady & ~r_aw_done}};
                    o_s_wValid  = w_wr_wvalid & ~r_w_done;
                    o_s_wData   = r_wr_grant ? i_m_wData[2*DWIDTH-1:DWIDTH] : i_m_wData[DWIDTH-1:0];
                    o_s_wStrb   = r_wr_grant ? i_m_wStrb[2*SWIDTH-1:SWIDTH] : i_m_wStrb[SWIDTH-1:0];
                    o_m_wReady  = w_wr_oh & {2{i_s_wReady & ~r_w_done}};
                end
                ST_RESP: begin
                    if (w_wr_to) begin
                        o_m_bValid = w_wr_oh;
                        o_m_bResp  = 2'b11;
                    end else begin
                        o_m_bValid = w_wr_oh & {2{i_s_bValid}};
                        o_s_bReady = r_wr_grant ? i_m_bReady[1] : i_m_bReady[0];
                        o_m_bResp  = i_s_bResp;
                    end
                end
                default: o_s_bReady = w_wr_drain;
            endcase
        end else begin
            o_s_bReady = 1'b0;
        end
    end

    // Read FSM and round-robin history.
    always_ff @(posedge i_aClk) begin
        if (i_aReset) begin
            r_rd_state    <= ST_IDLE;
            r_rd_grant    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_last_vld <= 1'b0;
        end else begin
            case (r_rd_state)
                ST_IDLE: begin
                    if (|i_m_arValid) begin
                        r_rd_grant <= w_rd_pick;
                        r_rd_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_fire) begin
                        r_rd_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_r_fire) begin
                        r_rd_state    <= ST_IDLE;
                        r_rd_last     <= r_rd_grant;
                        r_rd_last_vld <= 1'b1;
                    end
                end
                default: r_rd_state <= ST_IDLE;
            endcase
        end
    end

    // Write FSM, AW/W completion flags and round-robin history.
    always_ff @(posedge i_aClk) begin
        if (i_aReset) begin
            r_wr_state    <= ST_IDLE;
            r_wr_grant    <= 1'b0;
            r_wr_last     <= 1'b0;
            r_wr_last_vld <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
        end else begin
            case (r_wr_state)
                ST_IDLE: begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (|w_wr_req) begin
                        r_wr_grant <= w_wr_pick;
                        r_wr_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_aw_now && w_w_now) begin
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_wr_state <= ST_RESP;
                    end else begin
                        r_aw_done <= w_aw_now;
                        r_w_done  <= w_w_now;
                    end
                end
                ST_RESP: begin
                    if (w_b_fire) begin
                        r_wr_state    <= ST_IDLE;
                        r_wr_last     <= r_wr_grant;
                        r_wr_last_vld <= 1'b1;
                    end
                end
                default: r_wr_state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_rd_cnt, r_wr_cnt;
    logic          r_rd_to, r_wr_to, r_rd_drain, r_wr_drain, r_rd_tflag, r_wr_tflag;

    assign w_rd_to    = r_rd_to;
    assign w_wr_to    = r_wr_to;
    assign w_rd_drain = r_rd_drain;
    assign w_wr_drain = r_wr_drain;
    assign o_timeout  = {r_wr_tflag, r_rd_tflag};

    // Read response watchdog; after a timeout the late slave response is swallowed in IDLE.
    always_ff @(posedge i_aClk) begin
        if (i_aReset) begin
            r_rd_cnt   <= {CW{1'b0}};
            r_rd_to    <= 1'b0;
            r_rd_drain <= 1'b0;
            r_rd_tflag <= 1'b0;
        end else begin
            case (r_rd_state)
                ST_IDLE: begin
                    if ((|i_m_arValid) || i_s_rValid) begin
                        r_rd_drain <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    r_rd_cnt <= {CW{1'b0}};
                    r_rd_to  <= 1'b0;
                end
                ST_RESP: begin
                    if (w_r_fire) begin
                        if (r_rd_to) begin
                            r_rd_drain <= 1'b1;
                            r_rd_tflag <= 1'b1;
                        end
                    end else if (!r_rd_to && !i_s_rValid) begin
                        if (r_rd_cnt == CW'(TIMEOUT - 1)) begin
                            r_rd_to <= 1'b1;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + CW'(1);
                        end
                    end
                end
                default: r_rd_to <= 1'b0;
            endcase
        end
    end

    // Write response watchdog, mirror of the read one.
    always_ff @(posedge i_aClk) begin
        if (i_aReset) begin
            r_wr_cnt   <= {CW{1'b0}};
            r_wr_to    <= 1'b0;
            r_wr_drain <= 1'b0;
            r_wr_tflag <= 1'b0;
        end else begin
            case (r_wr_state)
                ST_IDLE: begin
                    if ((|w_wr_req) || i_s_bValid) begin
                        r_wr_drain <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    r_wr_cnt <= {CW{1'b0}};
                    r_wr_to  <= 1'b0;
                end
                ST_RESP: begin
                    if (w_b_fire) begin
                        if (r_wr_to) begin
                            r_wr_drain <= 1'b1;
                            r_wr_tflag <= 1'b1;
                        end
                    end else if (!r_wr_to && !i_s_bValid) begin
                        if (r_wr_cnt == CW'(TIMEOUT - 1)) begin
                            r_wr_to <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + CW'(1);
                        end
                    end
                end
                default: r_wr_to <= 1'b0;
            endcase
        end
    end
`else
    assign w_rd_to    = 1'b0;
    assign w_wr_to    = 1'b0;
    assign w_rd_drain = 1'b0;
    assign w_wr_drain = 1'b0;
`endif

endmodule

// File: tb/tb_axi4lite_arbiter_2to1.sv
// Directed bench for axi4lite_arbiter_2to1: reset, contention, round-robin writes,
// AW/W ordering, read/write concurrency and (with AXI_ARB_TIMEOUT_EN) the response timeout.
module tb_axi4lite_arbiter_2to1;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       m_arValid, m_arReady, m_rValid, m_rReady, m_rResp;
    logic [1:0]       m_awValid, m_awReady, m_wValid, m_wReady, m_bValid, m_bReady, m_bResp;
    logic [2*AW-1:0]  m_arAddr, m_awAddr;
    logic [5:0]       m_arProt, m_awProt;
    logic [DW-1:0]    m_rData;
    logic [2*DW-1:0]  m_wData;
    logic [2*SW-1:0]  m_wStrb;
    logic             s_arValid, s_arReady, s_rValid, s_rReady;
    logic             s_awValid, s_awReady, s_wValid, s_wReady, s_bValid, s_bReady;
    logic [AW-1:0]    s_arAddr, s_awAddr;
    logic [2:0]       s_arProt, s_awProt;
    logic [DW-1:0]    s_rData, s_wData;
    logic [SW-1:0]    s_wStrb;
    logic [1:0]       s_rResp, s_bResp;
`ifdef AXI_ARB_TIMEOUT_EN
    logic [1:0]       timeout;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int aw_cnt  = 0;
    int w_cnt   = 0;
    int aw0, w0;

    axi4lite_arbiter_2to1 #(
        .AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW)
`ifdef AXI_ARB_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .i_aClk(clk), .i_aReset(rst),
        .i_m_arValid(m_arValid), .o_m_arReady(m_arReady), .i_m_arAddr(m_arAddr), .i_m_arProt(m_arProt),
        .o_m_rValid(m_rValid), .i_m_rReady(m_rReady), .o_m_rData(m_rData), .o_m_rResp(m_rResp),
        .i_m_awValid(m_awValid), .o_m_awReady(m_awReady), .i_m_awAddr(m_awAddr), .i_m_awProt(m_awProt),
        .i_m_wValid(m_wValid), .o_m_wReady(m_wReady), .i_m_wData(m_wData), .i_m_wStrb(m_wStrb),
        .o_m_bValid(m_bValid), .i_m_bReady(m_bReady), .o_m_bResp(m_bResp),
        .o_s_arValid(s_arValid), .i_s_arReady(s_arReady), .o_s_arAddr(s_arAddr), .o_s_arProt(s_arProt),
        .i_s_rValid(s_rValid), .o_s_rReady(s_rReady), .i_s_rData(s_rData), .i_s_rResp(s_rResp),
        .o_s_awValid(s_awValid), .i_s_awReady(s_awReady), .o_s_awAddr(s_awAddr), .o_s_awProt(s_awProt),
        .o_s_wValid(s_wValid), .i_s_wReady(s_wReady), .o_s_wData(s_wData), .o_s_wStrb(s_wStrb),
        .i_s_bValid(s_bValid), .o_s_bReady(s_bReady), .i_s_bResp(s_bResp)
`ifdef AXI_ARB_TIMEOUT_EN
        , .o_timeout(timeout)
`endif
    );

    // Count handshakes actually forwarded to the slave.
    always @(posedge clk) begin
        if (s_awValid && s_awReady) aw_cnt <= aw_cnt + 1;
        if (s_wValid && s_wReady) w_cnt <= w_cnt + 1;
    end

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_arValid = 2'b11; m_awValid = 2'b11; m_wValid = 2'b11;
        m_rReady = 2'b11; m_bReady = 2'b11;
        m_arAddr = {12'h020, 12'h010}; m_awAddr = {12'h0B0, 12'h0A0};
        m_arProt = 6'b010_001; m_awProt = 6'b000_000;
        m_wData = {32'h22220000, 32'h11110000}; m_wStrb = 8'hFF;
        s_arReady = 1'b1; s_awReady = 1'b1; s_wReady = 1'b1;
        s_rValid = 1'b1; s_bValid = 1'b1; s_rData = 32'h0; s_rResp = 2'b00; s_bResp = 2'b00;

        // Reset held 3 cycles with every request asserted.
        repeat (3) @(negedge clk);
        #1;
        chk_eq("rst_m_ready", {m_arReady, m_awReady, m_wReady}, 6'b0);
        chk_eq("rst_m_valid", {m_rValid, m_bValid}, 4'b0);
        chk_eq("rst_s_valid", {s_arValid, s_awValid, s_wValid}, 3'b0);
        chk_eq("rst_s_ready", {s_rReady, s_bReady}, 2'b0);
        chk_eq("rst_s_data", {s_arAddr, s_awAddr, s_wData}, 56'h0);
        rst = 1'b0; m_awValid = 2'b00; m_wValid = 2'b00; s_rValid = 1'b0; s_bValid = 1'b0;
        #1;
        chk_eq("idle_no_ar", s_arValid, 1'b0);

        // Contention on AR: master 0 first, then master 1.
        @(negedge clk); #1;
        chk_eq("first_grant", m_arReady, 2'b01);
        chk_eq("m0_ar_addr", s_arAddr, 12'h010);
        chk_eq("m0_ar_prot", s_arProt, 3'b001);
        @(negedge clk);
        m_arValid = 2'b10; s_rValid = 1'b1; s_rData = 32'hA5A5A5A5;
        #1;
        chk_eq("m0_r_valid", m_rValid, 2'b01);
        chk_eq("m0_r_data", m_rData, 32'hA5A5A5A5);
        chk_eq("m1_ready_low_resp", m_arReady, 2'b00);
        @(negedge clk);
        s_rValid = 1'b0;
        #1;
        chk_eq("m1_ready_low_idle", m_arReady, 2'b00);
        @(negedge clk); #1;
        chk_eq("m1_grant", m_arReady, 2'b10);
        chk_eq("m1_ar_addr", s_arAddr, 12'h020);
        @(negedge clk);
        m_arValid = 2'b00; s_rValid = 1'b1; s_rData = 32'h5A5A5A5A;
        #1;
        chk_eq("m1_r_valid", m_rValid, 2'b10);
        chk_eq("m1_r_data", m_rData, 32'h5A5A5A5A);
        @(negedge clk);
        s_rValid = 1'b0;

        // Round-robin across 8 continuous write grants.
        m_awValid = 2'b11; m_wValid = 2'b11; s_bValid = 1'b1; s_bResp = 2'b00;
        for (int k = 0; k < 8; k++) begin
            for (int t = 0; t < 8; t++) begin
                @(negedge clk); #1;
                if (s_awValid) break;
            end
            chk_eq("rr_aw_valid", s_awValid, 1'b1);
            chk_eq("rr_grant", m_awReady, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk_eq("rr_addr", s_awAddr, (k % 2 == 0) ? 12'h0A0 : 12'h0B0);
            chk_eq("rr_wdata", s_wData, (k % 2 == 0) ? 32'h11110000 : 32'h22220000);
            @(negedge clk); #1;
            chk_eq("rr_b_route", m_bValid, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk_eq("rr_b_resp", m_bResp, 2'b00);
        end
        @(negedge clk);
        m_awValid = 2'b00; m_wValid = 2'b00; s_bValid = 1'b0;

        // W two cycles ahead of AW, slave stalls AW for 3 cycles.
        @(negedge clk);
        aw0 = aw_cnt; w0 = w_cnt;
        m_wValid = 2'b10; m_wData[63:32] = 32'hDEADBEEF; m_wStrb[7:4] = 4'b0011;
        m_awAddr[23:12] = 12'h004; s_awReady = 1'b0; s_wReady = 1'b1; m_bReady = 2'b10;
        @(negedge clk); #1;
        chk_eq("ord_w_valid", s_wValid, 1'b1);
        chk_eq("ord_w_data", s_wData, 32'hDEADBEEF);
        chk_eq("ord_w_strb", s_wStrb, 4'b0011);
        chk_eq("ord_w_ready", m_wReady, 2'b10);
        chk_eq("ord_aw_idle", s_awValid, 1'b0);
        @(negedge clk); #1;
        chk_eq("ord_w_masked", s_wValid, 1'b0);
        m_wValid = 2'b00; m_awValid = 2'b10;
        repeat (3) begin
            @(negedge clk); #1;
            chk_eq("ord_aw_stall_v", s_awValid, 1'b1);
            chk_eq("ord_aw_stall_r", m_awReady, 2'b00);
        end
        s_awReady = 1'b1;
        #1;
        chk_eq("ord_aw_ready", m_awReady, 2'b10);
        chk_eq("ord_aw_addr", s_awAddr, 12'h004);
        @(negedge clk);
        m_awValid = 2'b00; s_bValid = 1'b1; s_bResp = 2'b01;
        #1;
        chk_eq("ord_b_route", m_bValid, 2'b10);
        chk_eq("ord_b_resp", m_bResp, 2'b01);
        @(negedge clk);
        s_bValid = 1'b0;
        #1;
        chk_eq("ord_aw_count", aw_cnt - aw0, 1);
        chk_eq("ord_w_count", w_cnt - w0, 1);

        // Concurrent read by master 0 and write by master 1.
        @(negedge clk);
        m_arValid = 2'b01; m_arAddr[11:0] = 12'h100;
        m_awValid = 2'b10; m_wValid = 2'b10; m_awAddr[23:12] = 12'h200; m_wData[63:32] = 32'hCAFE0001;
        s_rValid = 1'b1; s_rData = 32'h12345678; s_rResp = 2'b00; s_bValid = 1'b1; s_bResp = 2'b00;
        m_rReady = 2'b11; m_bReady = 2'b11;
        @(negedge clk); #1;
        chk_eq("cc_ar_addr", s_arAddr, 12'h100);
        chk_eq("cc_aw_addr", s_awAddr, 12'h200);
        chk_eq("cc_w_data", s_wData, 32'hCAFE0001);
        @(negedge clk);
        m_arValid = 2'b00; m_awValid = 2'b00; m_wValid = 2'b00;
        #1;
        chk_eq("cc_r_valid", m_rValid, 2'b01);
        chk_eq("cc_r_data", m_rData, 32'h12345678);
        chk_eq("cc_b_valid", m_bValid, 2'b10);
        @(negedge clk);
        s_rValid = 1'b0; s_bValid = 1'b0;
        #1;
        chk_eq("cc_done", {m_rValid, m_bValid}, 4'b0);

`ifdef AXI_ARB_TIMEOUT_EN
        // Slave never answers the read; arbiter completes it with DECERR.
        @(negedge clk);
        m_arValid = 2'b01; m_arAddr[11:0] = 12'h300; m_rReady = 2'b01;
        @(negedge clk);
        @(negedge clk);
        m_arValid = 2'b00;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk_eq("to_wait", m_rValid, 2'b00);
            @(negedge clk);
        end
        #1;
        chk_eq("to_r_valid", m_rValid, 2'b01);
        chk_eq("to_r_resp", m_rResp, 2'b11);
        chk_eq("to_r_data", m_rData, 32'h0);
        @(negedge clk); #1;
        chk_eq("to_flag", timeout, 2'b01);
        chk_eq("to_drain_ready", s_rReady, 1'b1);
        s_rValid = 1'b1; s_rData = 32'hBAD0BAD0;
        #1;
        chk_eq("to_late_hidden", m_rValid, 2'b00);
        @(negedge clk);
        s_rValid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
